// File: rtl/ex_alu_seq.sv
// ex_alu_seq: execute-stage ALU, registered result over valid/ready; 1-cycle ops, serial 1-bit/cycle shifts.
// Define FAST_SHIFT_EN for a single-cycle barrel shifter; new ops stall while a shift runs or a result is unconsumed.
`ifndef ALU_SEL_W
`define ALU_SEL_W 4
`endif

module ex_alu_seq #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [`ALU_SEL_W-1:0] ALUCtl,
  input  logic [XLEN-1:0]       src_a,
  input  logic [XLEN-1:0]       src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       result,
  output logic                  taken,
  output logic                  illegal,
  output logic                  busy
);

  localparam logic [`ALU_SEL_W-1:0] ALU_ERROR = `ALU_SEL_W'(0);
  localparam logic [`ALU_SEL_W-1:0] ALU_ADD   = `ALU_SEL_W'(1);
  localparam logic [`ALU_SEL_W-1:0] ALU_SUB   = `ALU_SEL_W'(2);
  localparam logic [`ALU_SEL_W-1:0] ALU_AND   = `ALU_SEL_W'(3);
  localparam logic [`ALU_SEL_W-1:0] ALU_OR    = `ALU_SEL_W'(4);
  localparam logic [`ALU_SEL_W-1:0] ALU_XOR   = `ALU_SEL_W'(5);
  localparam logic [`ALU_SEL_W-1:0] ALU_SLL   = `ALU_SEL_W'(6);
  localparam logic [`ALU_SEL_W-1:0] ALU_SRL   = `ALU_SEL_W'(7);
  localparam logic [`ALU_SEL_W-1:0] ALU_SRA   = `ALU_SEL_W'(8);
  localparam logic [`ALU_SEL_W-1:0] ALU_SLT   = `ALU_SEL_W'(9);
  localparam logic [`ALU_SEL_W-1:0] ALU_SLTU  = `ALU_SEL_W'(10);
  localparam logic [`ALU_SEL_W-1:0] ALU_BNE   = `ALU_SEL_W'(11);
  localparam logic [`ALU_SEL_W-1:0] ALU_BLT   = `ALU_SEL_W'(12);
  localparam logic [`ALU_SEL_W-1:0] ALU_BGE   = `ALU_SEL_W'(13);
  localparam logic [`ALU_SEL_W-1:0] ALU_BLTU  = `ALU_SEL_W'(14);
  localparam logic [`ALU_SEL_W-1:0] ALU_BGEU  = `ALU_SEL_W'(15);

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

  state_t                  state, state_nxt;
  logic [SHAMT_W-1:0]      shamt;
  logic [SHAMT_W-1:0]      cnt;
  logic [XLEN-1:0]         shreg, sh_nxt;
  logic [`ALU_SEL_W-1:0]   op;
  logic [XLEN-1:0]         diff;
  logic                    lt_s, lt_u;
  logic [XLEN-1:0]         alu_res;
  logic                    alu_tk, alu_il, is_shift;
  logic                    accept, shift_start;

  assign shamt    = src_b[SHAMT_W-1:0];
  assign diff     = src_a - src_b;
  assign lt_s     = $signed(src_a) < $signed(src_b);
  assign lt_u     = src_a < src_b;
  assign busy     = (state == SHIFT);
  assign in_ready = (state == IDLE) & (!out_valid | out_ready) & !flush;
  assign accept   = in_valid & in_ready;

`ifdef FAST_SHIFT_EN
  assign shift_start = 1'b0;
`else
  assign shift_start = accept & is_shift & (shamt != '0);
`endif

  always_comb begin
    alu_res  = '0;
    alu_tk   = 1'b0;
    alu_il   = 1'b0;
    is_shift = 1'b0;
    case (ALUCtl)
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_SUB:  begin alu_res = diff; alu_tk = (diff == '0); end
      ALU_AND:  alu_res = src_a & src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_XOR:  alu_res = src_a ^ src_b;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
      ALU_BNE:  begin alu_res = diff; alu_tk = (diff != '0); end
      ALU_BLT:  begin alu_res = diff; alu_tk = lt_s;  end
      ALU_BGE:  begin alu_res = diff; alu_tk = !lt_s; end
      ALU_BLTU: begin alu_res = diff; alu_tk = lt_u;  end
      ALU_BGEU: begin alu_res = diff; alu_tk = !lt_u; end
`ifdef FAST_SHIFT_EN
      ALU_SLL:  begin is_shift = 1'b1; alu_res = src_a << shamt; end
      ALU_SRL:  begin is_shift = 1'b1; alu_res = src_a >> shamt; end
      ALU_SRA:  begin is_shift = 1'b1; alu_res = XLEN'($signed(src_a) >>> shamt); end
`else
      // Only the shamt==0 case completes here; nonzero amounts go through SHIFT.
      ALU_SLL, ALU_SRL, ALU_SRA: begin is_shift = 1'b1; alu_res = src_a; end
`endif
      default:  alu_il = 1'b1;
    endcase
  end

  always_comb begin
    case (op)
      ALU_SLL: sh_nxt = {shreg[XLEN-2:0], 1'b0};
      ALU_SRL: sh_nxt = {1'b0, shreg[XLEN-1:1]};
      default: sh_nxt = {shreg[XLEN-1], shreg[XLEN-1:1]};
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (shift_start) state_nxt = SHIFT;
      SHIFT:   if (cnt == SHAMT_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) state <= IDLE;
    else                state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      taken     <= 1'b0;
      illegal   <= 1'b0;
      cnt       <= '0;
      shreg     <= '0;
      op        <= ALU_ERROR;
    end else if (flush) begin
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        taken   <= alu_tk;
        illegal <= alu_il;
        if (shift_start) begin
          shreg <= src_a;
          cnt   <= shamt;
          op    <= ALUCtl;
        end else begin
          result    <= alu_res;
          out_valid <= 1'b1;
        end
      end else if (state == SHIFT) begin
        shreg <= sh_nxt;
        cnt   <= cnt - SHAMT_W'(1);
        if (cnt == SHAMT_W'(1)) begin
          result    <= sh_nxt;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule
